// File: rtl/xor_stream_cipher.sv
// xor_stream_cipher: loads a variable-length key, then XORs a message stream against it cyclically with valid/ready handshakes.
module xor_stream_cipher #(
  parameter int DATA_W = 8,
  parameter int KEY_DEPTH = 64,
  parameter int MAX_LEN = 512,
  localparam int KW = $clog2(KEY_DEPTH + 1),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iKey_reuse,
  input  logic [KW-1:0]     iKey_len,
  input  logic [LW-1:0]     iMsg_len,
  input  logic              iKey_valid,
  input  logic [DATA_W-1:0] iKey_data,
  output logic              oKey_ready,
  input  logic              iMsg_valid,
  input  logic [DATA_W-1:0] iMsg_data,
  output logic              oMsg_ready,
  output logic              oCt_valid,
  output logic [DATA_W-1:0] oCt_data,
  input  logic              iCt_ready,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr
);
  localparam int AW = KEY_DEPTH > 1 ? $clog2(KEY_DEPTH) : 1;
  localparam logic [KW-1:0] KMAX = KW'(KEY_DEPTH);
  localparam logic [LW-1:0] LMAX = LW'(MAX_LEN);
  typedef enum logic [1:0] {IDLE, LOAD_KEY, CRYPT, DONE} stateT;
  stateT state, stateNext;
  logic [DATA_W-1:0] keyMem [KEY_DEPTH];
  logic [KW-1:0] keyLen, kidx;
  logic [LW-1:0] msgLen, inCnt, outCnt;
  logic keyLoaded, startTake, reject, keyHs, msgHs, ctHs, kidxLast, lastOut;
  always_comb begin
    reject = iMsg_len == '0 || iMsg_len > LMAX ||
             (!iKey_reuse && (iKey_len == '0 || iKey_len > KMAX)) ||
             (iKey_reuse && !keyLoaded);
    startTake = iStart && (state == IDLE || state == DONE);
    oKey_ready = state == LOAD_KEY;
    oMsg_ready = state == CRYPT && inCnt < msgLen && (!oCt_valid || iCt_ready);
    oBusy = state == LOAD_KEY || state == CRYPT;
    keyHs = oKey_ready && iKey_valid;
    msgHs = oMsg_ready && iMsg_valid;
    ctHs = oCt_valid && iCt_ready;
    kidxLast = kidx == keyLen - KW'(1);
    lastOut = ctHs && outCnt == msgLen - LW'(1);
    stateNext = startTake ? (reject ? IDLE : iKey_reuse ? CRYPT : LOAD_KEY) :
                keyHs && kidxLast ? CRYPT :
                lastOut ? DONE : state;
  end
  always_ff @(posedge iClk)
    if (keyHs) keyMem[kidx[AW-1:0]] <= iKey_data;
  always_ff @(posedge iClk or negedge iRst)
    if (!iRst) begin
      state <= IDLE;
      keyLen <= '0;
      kidx <= '0;
      msgLen <= '0;
      inCnt <= '0;
      outCnt <= '0;
      keyLoaded <= 1'b0;
      oCt_valid <= 1'b0;
      oCt_data <= '0;
      oDone <= 1'b0;
      oErr <= 1'b0;
    end else begin
      state <= stateNext;
      if (startTake) begin
        oDone <= 1'b0;
        oErr <= reject;
        kidx <= '0;
        inCnt <= '0;
        outCnt <= '0;
        if (!reject) msgLen <= iMsg_len;
        if (!reject && !iKey_reuse) keyLen <= iKey_len;
      end
      if (keyHs) begin
        kidx <= kidxLast ? '0 : kidx + KW'(1);
        keyLoaded <= keyLoaded || kidxLast;
      end
      if (msgHs) begin
        oCt_data <= iMsg_data ^ keyMem[kidx[AW-1:0]];
        inCnt <= inCnt + LW'(1);
        kidx <= kidxLast ? '0 : kidx + KW'(1);
      end
      if (ctHs) outCnt <= outCnt + LW'(1);
      oCt_valid <= msgHs || (oCt_valid && !iCt_ready);
      if (lastOut) oDone <= 1'b1;
    end
endmodule

// File: tb/tb_xor_stream_cipher.sv
// tb_xor_stream_cipher: directed and randomized checks against a modulo-indexed key reference model.
module tb_xor_stream_cipher;
  localparam int DATA_W = 8;
  localparam int KEY_DEPTH = 64;
  localparam int MAX_LEN = 512;
  localparam int KW = $clog2(KEY_DEPTH + 1);
  localparam int LW = $clog2(MAX_LEN + 1);
  logic iClk = 1'b0;
  logic iRst = 1'b0;
  logic iStart = 1'b0;
  logic iKey_reuse = 1'b0;
  logic [KW-1:0] iKey_len = '0;
  logic [LW-1:0] iMsg_len = '0;
  logic iKey_valid = 1'b0;
  logic [DATA_W-1:0] iKey_data = '0;
  logic oKey_ready;
  logic iMsg_valid = 1'b0;
  logic [DATA_W-1:0] iMsg_data = '0;
  logic oMsg_ready;
  logic oCt_valid;
  logic [DATA_W-1:0] oCt_data;
  logic iCt_ready = 1'b0;
  logic oBusy;
  logic oDone;
  logic oErr;
  int checks = 0;
  int errors = 0;
  int curKeyLen = 1;
  int cyc;
  logic [DATA_W-1:0] keyArr [KEY_DEPTH];
  logic [DATA_W-1:0] msgArr [MAX_LEN];

  xor_stream_cipher #(.DATA_W(DATA_W), .KEY_DEPTH(KEY_DEPTH), .MAX_LEN(MAX_LEN)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iKey_reuse(iKey_reuse),
    .iKey_len(iKey_len), .iMsg_len(iMsg_len), .iKey_valid(iKey_valid),
    .iKey_data(iKey_data), .oKey_ready(oKey_ready), .iMsg_valid(iMsg_valid),
    .iMsg_data(iMsg_data), .oMsg_ready(oMsg_ready), .oCt_valid(oCt_valid),
    .oCt_data(oCt_data), .iCt_ready(iCt_ready), .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic startOp(input bit reuse, input int klen, input int mlen);
    iStart = 1'b1;
    iKey_reuse = reuse;
    iKey_len = KW'(klen);
    iMsg_len = LW'(mlen);
    @(negedge iClk);
    iStart = 1'b0;
  endtask

  task automatic loadKey(input int klen);
    int idx = 0;
    int n = 0;
    while (idx < klen && n < 2000) begin
      iKey_valid = $urandom_range(0, 3) != 0;
      iKey_data = keyArr[idx];
      #1;
      if (iKey_valid && oKey_ready) idx++;
      @(negedge iClk);
      n++;
    end
    iKey_valid = 1'b0;
    curKeyLen = klen;
    chk("keyLoadCount", idx, klen);
    chk("keyReadyAfterLoad", oKey_ready, 0);
    chk("busyInCrypt", oBusy, 1);
  endtask

  task automatic crypt(input int mlen, input int mode, output int cycles);
    int sent = 0;
    int got = 0;
    int n = 0;
    bit prevStall = 0;
    bit accepted = 0;
    logic [DATA_W-1:0] prevData = '0;
    while (got < mlen && n < 5000) begin
      iCt_ready = mode == 0 ? 1'b1 : mode == 1 ? (n % 2 == 0) : ($urandom_range(0, 2) != 0);
      iMsg_valid = sent < mlen && (mode != 2 || $urandom_range(0, 3) != 0);
      iMsg_data = sent < mlen ? msgArr[sent] : '0;
      #1;
      if (accepted) chk("latency", oCt_valid, 1);
      if (prevStall) chk("hold", oCt_data, prevData);
      chk("noAcceptWhileStalled", oMsg_ready && oCt_valid && !iCt_ready, 0);
      if (sent == mlen) chk("noExtraAccept", oMsg_ready, 0);
      if (oCt_valid && iCt_ready) begin
        chk($sformatf("ct%0d", got), oCt_data, msgArr[got] ^ keyArr[got % curKeyLen]);
        got++;
      end
      accepted = iMsg_valid && oMsg_ready;
      if (accepted) sent++;
      prevStall = oCt_valid && !iCt_ready;
      prevData = oCt_data;
      @(negedge iClk);
      n++;
    end
    iMsg_valid = 1'b0;
    iCt_ready = 1'b0;
    chk("outCount", got, mlen);
    chk("doneSet", oDone, 1);
    chk("busyClear", oBusy, 0);
    chk("ctValidClear", oCt_valid, 0);
    cycles = n;
  endtask

  initial begin
    repeat (2) @(negedge iClk);
    chk("rstCtValid", oCt_valid, 0);
    chk("rstBusy", oBusy, 0);
    chk("rstDone", oDone, 0);
    chk("rstErr", oErr, 0);
    chk("rstKeyReady", oKey_ready, 0);
    chk("rstMsgReady", oMsg_ready, 0);
    iRst = 1'b1;
    @(negedge iClk);
    startOp(1, 4, 6);
    chk("reuseNoKeyErr", oErr, 1);
    chk("reuseNoKeyBusy", oBusy, 0);
    startOp(0, 4, MAX_LEN + 1);
    chk("msgTooLongErr", oErr, 1);
    startOp(0, 4, 0);
    chk("msgZeroErr", oErr, 1);
    startOp(0, 0, 6);
    chk("keyZeroErr", oErr, 1);
    startOp(0, KEY_DEPTH + 1, 6);
    chk("keyTooLongErr", oErr, 1);
    chk("keyTooLongIdle", oKey_ready, 0);
    for (int i = 0; i < 4; i++) keyArr[i] = DATA_W'(i + 1);
    for (int i = 0; i < 6; i++) msgArr[i] = 8'h10;
    startOp(0, 4, 6);
    chk("validStartClearsErr", oErr, 0);
    chk("loadKeyReady", oKey_ready, 1);
    loadKey(4);
    crypt(6, 0, cyc);
    chk("throughput6", cyc, 7);
    startOp(0, 4, 6);
    chk("startClearsDone", oDone, 0);
    loadKey(4);
    crypt(6, 1, cyc);
    msgArr[0] = 8'hAA;
    msgArr[1] = 8'h55;
    startOp(1, 0, 2);
    chk("reuseSkipsLoad", oKey_ready, 0);
    chk("reuseBusy", oBusy, 1);
    chk("reuseErr", oErr, 0);
    crypt(2, 0, cyc);
    chk("throughput2", cyc, 3);
    startOp(0, 4, 0);
    chk("rejectFromDoneErr", oErr, 1);
    chk("rejectFromDoneClearsDone", oDone, 0);
    startOp(1, 0, 2);
    chk("reuseAfterRejectErr", oErr, 0);
    crypt(2, 2, cyc);
    keyArr[0] = DATA_W'($urandom);
    for (int i = 0; i < 9; i++) msgArr[i] = DATA_W'($urandom);
    startOp(0, 1, 9);
    loadKey(1);
    crypt(9, 2, cyc);
    for (int i = 0; i < 10; i++) keyArr[i] = DATA_W'($urandom);
    for (int i = 0; i < 4; i++) msgArr[i] = DATA_W'($urandom);
    startOp(0, 10, 4);
    loadKey(10);
    crypt(4, 2, cyc);
    for (int i = 0; i < 4; i++) keyArr[i] = DATA_W'($urandom);
    startOp(0, 4, 8);
    loadKey(4);
    for (int i = 0; i < 3; i++) begin
      iMsg_valid = 1'b1;
      iCt_ready = 1'b1;
      iMsg_data = DATA_W'($urandom);
      @(negedge iClk);
    end
    chk("preResetValid", oCt_valid, 1);
    #2 iRst = 1'b0;
    #1;
    chk("asyncRstCtValid", oCt_valid, 0);
    chk("asyncRstCtData", oCt_data, 0);
    chk("asyncRstBusy", oBusy, 0);
    chk("asyncRstDone", oDone, 0);
    chk("asyncRstMsgReady", oMsg_ready, 0);
    iMsg_valid = 1'b0;
    iCt_ready = 1'b0;
    @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    startOp(1, 0, 4);
    chk("reuseAfterRstErr", oErr, 1);
    for (int i = 0; i < KEY_DEPTH; i++) keyArr[i] = DATA_W'($urandom);
    for (int i = 0; i < MAX_LEN; i++) msgArr[i] = DATA_W'($urandom);
    startOp(0, KEY_DEPTH, MAX_LEN);
    loadKey(KEY_DEPTH);
    crypt(MAX_LEN, 0, cyc);
    chk("throughputMax", cyc, MAX_LEN + 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/xor_stream_cipher.md
Name: xor_stream_cipher

Overview:
- Streaming, parametrised successor to the fixed-width one-shot XOR encryptor.
- Loads a variable-length key one symbol at a time into internal storage.
- XORs a variable-length message stream against the key, repeating the key cyclically, with valid/ready handshakes on every interface and one symbol per cycle throughput.
- Sits between the UART/byte assembler front end and the ciphertext serializer. Supports key reuse across messages and reports length/config errors.

Parameters:
- DATA_W, 8: symbol width in bits for key, message and ciphertext.
- KEY_DEPTH, 64: maximum key length in symbols; sizes the key register file.
- MAX_LEN, 512: maximum message length in symbols.
- Derived localparams: KW = $clog2(KEY_DEPTH+1), LW = $clog2(MAX_LEN+1).

Ports:
- iClk  in  1  clock, rising edge.
- iRst  in  1  asynchronous active-low reset.
- iStart  in  1  single-cycle start request.
- iKey_reuse  in  1  sampled with iStart; 1 = skip key load and use the stored key.
- iKey_len  in  KW  key length in symbols; sampled with iStart.
- iMsg_len  in  LW  message length in symbols; sampled with iStart.
- iKey_valid  in  1  key symbol valid.
- iKey_data  in  DATA_W  key symbol.
- oKey_ready  out  1  key symbol accepted when valid & ready.
- iMsg_valid  in  1  plaintext symbol valid.
- iMsg_data  in  DATA_W  plaintext symbol.
- oMsg_ready  out  1  plaintext accepted when valid & ready.
- oCt_valid  out  1  ciphertext symbol valid.
- oCt_data  out  DATA_W  ciphertext symbol.
- iCt_ready  in  1  downstream accepts ciphertext.
- oBusy  out  1  high in LOAD_KEY or CRYPT.
- oDone  out  1  sticky; message fully delivered.
- oErr  out  1  sticky; last iStart was rejected.

Behaviour:
- Reset (iRst=0, asynchronous):
  - State = IDLE; all outputs 0; counters and key_loaded flag cleared.
  - Key storage is not reset and is never read before being written.
  - Reset mid-operation aborts immediately. Any partially delivered message is discarded; no oDone.
- States: IDLE, LOAD_KEY, CRYPT, DONE.
- Starting from IDLE or DONE (iStart=1):
  - Latch lengths; clear oDone and oErr.
  - Reject (oErr<=1, go to IDLE) if any of the following holds:
    - iMsg_len==0 or iMsg_len>MAX_LEN;
    - iKey_reuse=0 and (iKey_len==0 or iKey_len>KEY_DEPTH);
    - iKey_reuse=1 and key_loaded=0.
  - Otherwise go to LOAD_KEY if iKey_reuse=0, or CRYPT if iKey_reuse=1. The reuse path keeps the previously stored key length and ignores iKey_len.
  - iStart is ignored in LOAD_KEY and CRYPT.
- LOAD_KEY:
  - oKey_ready=1.
  - Each handshake writes key_mem[kidx] and increments kidx.
  - The handshake at kidx==key_len-1 sets key_loaded=1, sets kidx=0 and moves to CRYPT on the next cycle.
  - oKey_ready=0 in every other state; key symbols offered then are not consumed.
- CRYPT (single-entry output register):
  - oMsg_ready = (in_cnt<msg_len) && (!oCt_valid || iCt_ready).
  - On a message handshake:
    - oCt_data <= iMsg_data ^ key_mem[kidx]; oCt_valid <= 1.
    - in_cnt++.
    - kidx wraps to 0 after key_len-1; otherwise kidx++.
  - Latency: plaintext accepted at cycle N is presented as ciphertext at cycle N+1.
  - Output hold: oCt_valid falls on (oCt_valid & iCt_ready) with no simultaneous accept. oCt_data stays stable while oCt_valid=1 and iCt_ready=0.
  - Simultaneous drain and accept keeps oCt_valid=1 and gives a full one-symbol-per-cycle stream.
  - out_cnt increments on each ciphertext handshake.
  - When out_cnt reaches msg_len: go to DONE, oDone <= 1, oCt_valid = 0.
- DONE: oDone remains 1 until the next accepted or rejected iStart. Key storage and key_loaded are retained.
- Key length 1 means every symbol uses key_mem[0]. Key longer than the message means the unused key tail is ignored.
- kidx resets to 0 at the start of every message, including on the reuse path.
- All XOR is bitwise, DATA_W wide, with no carries.

Test Plan:
- Reset, then iStart with key_len=4, key {01,02,03,04}, msg_len=6, msg {10,10,10,10,10,10}, iCt_ready=1 -> ciphertext {11,12,13,14,11,12}; each output 1 cycle after its accept; oDone=1 after the 6th handshake; oBusy=0.
- Same key, iCt_ready toggling 1010…, iMsg_valid always 1 -> oCt_data is held while stalled; no symbol is lost or duplicated; 6 outputs total; oMsg_ready is never high while oCt_valid & !iCt_ready.
- After DONE, iStart with iKey_reuse=1, msg_len=2, msg {AA,55} -> no LOAD_KEY cycle; output {AB,57}.
- iStart with iKey_reuse=1 directly after reset -> oErr=1, state IDLE. iStart with iMsg_len=MAX_LEN+1 -> oErr=1. The next valid iStart clears oErr.
- Assert iRst low mid-CRYPT after 3 symbols -> all outputs 0 asynchronously; the following iStart with iKey_reuse=1 -> oErr=1 (key_loaded cleared).
- MAX_LEN=512, key_len=KEY_DEPTH=64, streaming random data with iCt_ready=1 -> 512 outputs in 512 consecutive cycles, matching a reference model with cyclic key index.
